seq_mult_radix4: RTL
====================

Name: seq_mult_radix4

Overview:
- Parametrised iterative unsigned integer multiplier, SIZE x SIZE -> 2*SIZE.
- Retires one radix-4 digit of B (two bits) per clock, so a full product takes SIZE/2 cycles.
- Uses a 0/A/2A/3A digit-multiple selector and a single shared SIZE+2-bit adder, instead of an unrolled adder array.
- Sits beside the combinational multipliers as the area-optimised option and is driven by a Start/Done handshake from datapath control.

Parameters:
- SIZE, 16, operand width; must be even and >= 4 (elaboration error otherwise).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- A  input  SIZE  multiplicand; captured on the accepting edge.
- B  input  SIZE  multiplier; captured on the accepting edge.
- Signed  input  1  two's-complement mode select; exists only with SEQ_MULT_SIGNED_EN.
- Result  output  2*SIZE  product; registered, held until the next completion.
- Busy  output  1  high while a multiplication is in progress.
- Done  output  1  one-cycle pulse; Result is valid in this cycle.

Behaviour:
- Reset (synchronous, active-high) sets state=IDLE and clears Result=0, Busy=0, Done=0, digit counter=0 and accumulator=0.
- Reset has priority over every other event, including mid-CALC; an in-flight operation is discarded and no Done is produced.

States:
- IDLE: waits for Start. Start=1 latches A, B (and Signed), loads counter=SIZE/2-1, and moves to CALC.
- CALC: each edge
  - selects multiple M = {0, A, 2A, 3A} from the two LSBs of the B shift register; M is SIZE+2 bits wide;
  - adds M to the upper SIZE+2 bits of the accumulator, keeping the carry;
  - shifts the accumulator and the B register right by 2;
  - decrements the counter.
  On the edge where counter==0, the final sum is written to Result and the state moves to DONE.
- DONE: Done=1 and Busy=0 for exactly one cycle. Start=1 in this cycle is accepted (back-to-back, same as IDLE) and moves to CALC; otherwise the state returns to IDLE.

Timing and handshake:
- Latency: if Start is sampled on edge t0, Result updates on edge t0+SIZE/2 and Done is high in the cycle that follows.
- Throughput: one product per SIZE/2+1 cycles.
- Busy=1 from edge t0 up to edge t0+SIZE/2.
- Start while Busy=1 is ignored; operands are not re-sampled and the in-flight result is unaffected.
- A and B may change freely after the accepting edge.
- Result is exact (unsigned A*B < 2^(2*SIZE)) and holds its value through IDLE until the next completion.
- Boundary cases: A=0 or B=0 gives Result=0 with the same full latency (no early exit); all-ones operands must not lose the top carry.

Optional Feature:
SEQ_MULT_SIGNED_EN
- Defined: the Signed port exists.
  - Signed=1: on accept, A and B are replaced by their absolute values and sign = A[SIZE-1]^B[SIZE-1] is registered.
  - At completion, Result is two's-complement negated if sign=1.
  - Latency is unchanged.
  - The most negative value (-2^(SIZE-1)) is handled: its magnitude fits in SIZE unsigned bits.
  - Signed=0 behaves as unsigned.
- Undefined: no Signed port; unsigned only, with no extra logic.

Decomposition:
- Shared package seq_mult_pkg holds:
  - state encoding (IDLE, CALC, DONE);
  - function for counter width, clog2(SIZE/2) with a minimum of 1;
  - DIGIT_BITS=2.
- One sub-module, radix4_digit_sel: combinational, SIZE-bit A plus 2-bit digit in, SIZE+2-bit multiple out.
- Adder, counter and FSM stay in the top module.

Test Plan:
- SIZE=16, A=0xFFFF, B=0xFFFF, Start one cycle -> Busy high for 8 cycles, Done pulses on the 9th cycle, Result=0xFFFE0001.
- SIZE=16, A=0x1234, B=0x0000 -> Result=0x00000000, Done at the same latency (no early exit).
- SIZE=16, start A=3, B=5; Start=1 again with A=7, B=7 at cycle 3 -> ignored, Result=0x0000000F. Start held high in the DONE cycle with A=7, B=7 -> next Result=0x00000031 exactly 9 cycles later.
- Reset asserted at CALC cycle 4 -> next cycle Busy=0, Done=0, Result=0; no Done pulse appears afterwards.
- SIZE=4, A=0xF, B=0xF -> Done after 2 CALC cycles, Result=0xE1. With SIZE=4 and randomised operands over 1000 runs -> Result matches A*B every run.
- SEQ_MULT_SIGNED_EN, SIZE=16, Signed=1:
  - A=0xFFFD (-3), B=0x0005 -> Result=0xFFFFFFF1;
  - A=0x8000, B=0x8000 -> Result=0x40000000;
  - Signed=0 with A=0xFFFD, B=5 -> Result=0x0004FFF1.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the radix-4 sequential multiplier: FSM state
// encoding, digit width and the digit-counter width helper.
package seq_mult_pkg;

    // Bits of the multiplier retired per clock (one radix-4 digit).
    localparam int DIGIT_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Digit counter width: clog2(size/2), never narrower than one bit.
    function automatic int cnt_width(input int size);
        int w;
        w = $clog2(size / 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_mult_radix4_if.sv
// Start/Done handshake and operand/result bus of the sequential multiplier.
// The signed-mode select only exists when SEQ_MULT_SIGNED_EN is defined.
interface seq_mult_radix4_if #(
    parameter int SIZE = 16
);
    logic                  start;
    logic [SIZE-1:0]       a;
    logic [SIZE-1:0]       b;
`ifdef SEQ_MULT_SIGNED_EN
    logic                  signed_mode;
`endif
    logic [2*SIZE-1:0]     result;
    logic                  busy;
    logic                  done;

`ifdef SEQ_MULT_SIGNED_EN
    modport master (output start, a, b, signed_mode, input result, busy, done);
    modport slave  (input start, a, b, signed_mode, output result, busy, done);
`else
    modport master (output start, a, b, input result, busy, done);
    modport slave  (input start, a, b, output result, busy, done);
`endif
endinterface

// File: rtl/seq_mult_radix4_digit_sel.sv
// Radix-4 digit multiple selector: returns 0, A, 2A or 3A for a 2-bit digit.
// The output is two bits wider than A so that 3A never overflows.
module radix4_digit_sel #(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0] a_i,
    input  logic [1:0]      digit_i,
    output logic [SIZE+1:0] mult_o
);
    logic [SIZE+1:0] a1_s;
    logic [SIZE+1:0] a2_s;

    assign a1_s = {2'b00, a_i};
    assign a2_s = {1'b0, a_i, 1'b0};

    // Pick the multiple of A selected by the current digit.
    always_comb begin
        mult_o = '0;
        case (digit_i)
            2'd0:    mult_o = '0;
            2'd1:    mult_o = a1_s;
            2'd2:    mult_o = a2_s;
            2'd3:    mult_o = a1_s + a2_s;
            default: mult_o = '0;
        endcase
    end
endmodule

// File: rtl/seq_mult_radix4.sv
// Iterative SIZE x SIZE -> 2*SIZE multiplier retiring one radix-4 digit of B
// per clock through a single shared SIZE+2-bit adder.
// Optional build macro SEQ_MULT_SIGNED_EN adds a two's-complement mode
// (magnitude multiply, sign applied to the final product).
module seq_mult_radix4
    import seq_mult_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    seq_mult_radix4_if.slave  bus
);
    localparam int                CNT_W    = cnt_width(SIZE);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SIZE / 2 - 1);

    if (((SIZE % 2) != 0) || (SIZE < 4)) begin : g_bad_size
        $error("seq_mult_radix4: SIZE must be even and >= 4");
    end

    state_e              state_q, state_d;
    logic [SIZE-1:0]     a_q, a_d;
    logic [SIZE-1:0]     b_q, b_d;
    logic [2*SIZE-1:0]   acc_q, acc_d;
    logic [2*SIZE-1:0]   result_q, result_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept_s;
    logic [SIZE-1:0]     a_load_s;
    logic [SIZE-1:0]     b_load_s;
    logic [SIZE+1:0]     mult_s;
    logic [SIZE+1:0]     sum_s;
    logic [2*SIZE-1:0]   acc_step_s;
    logic [2*SIZE-1:0]   final_s;

    // A new operation is taken whenever no calculation is in flight.
    assign accept_s = bus.start && (state_q != ST_CALC);

    radix4_digit_sel #(.SIZE(SIZE)) u_digit_sel (
        .a_i     (a_q),
        .digit_i (b_q[DIGIT_BITS-1:0]),
        .mult_o  (mult_s)
    );

    // The upper half stays below 2^SIZE, so hi + 3A always fits in SIZE+2 bits.
    assign sum_s      = {2'b00, acc_q[2*SIZE-1:SIZE]} + mult_s;
    assign acc_step_s = {sum_s, acc_q[SIZE-1:DIGIT_BITS]};

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_q;
    logic sign_load_s;

    // Convert signed operands to magnitudes; -2^(SIZE-1) maps to itself as unsigned.
    always_comb begin
        if (bus.signed_mode) begin
            a_load_s    = bus.a[SIZE-1] ? -bus.a : bus.a;
            b_load_s    = bus.b[SIZE-1] ? -bus.b : bus.b;
            sign_load_s = bus.a[SIZE-1] ^ bus.b[SIZE-1];
        end else begin
            a_load_s    = bus.a;
            b_load_s    = bus.b;
            sign_load_s = 1'b0;
        end
    end

    // Product sign register, captured with the operands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sign_q <= 1'b0;
        end else if (accept_s) begin
            sign_q <= sign_load_s;
        end else begin
            sign_q <= sign_q;
        end
    end

    assign final_s = sign_q ? -acc_step_s : acc_step_s;
`else
    assign a_load_s = bus.a;
    assign b_load_s = bus.b;
    assign final_s  = acc_step_s;
`endif

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath control: accept, iterate one digit, complete.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d = ST_CALC;
                    a_d     = a_load_s;
                    b_d     = b_load_s;
                    acc_d   = '0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_CALC: begin
                acc_d = acc_step_s;
                b_d   = b_q >> DIGIT_BITS;
                if (cnt_q == '0) begin
                    result_d = final_s;
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule
